// File: rtl/data_sync.sv
// Multi-bit CDC synchronizer: level enable crosses through a flop chain,
// its rising edge captures the held data bus and emits a one-cycle pulse.
module data_sync #(
    parameter int NUM_STAGES = 2,
    parameter int BUS_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BUS_WIDTH-1:0] unsync_bus,
    input  logic                 bus_enable,
    output logic [BUS_WIDTH-1:0] sync_bus,
    output logic                 enable_pulse
);

    logic [NUM_STAGES-1:0] chain;
    logic                  prev;
    logic                  pulse_comb;

    // Only the enable is multi-flop synchronized; the bus is sampled once
    // after the enable has settled, relying on the source holding it stable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[NUM_STAGES-2:0], bus_enable};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev <= 1'b0;
        end else begin
            prev <= chain[NUM_STAGES-1];
        end
    end

    assign pulse_comb = chain[NUM_STAGES-1] & ~prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_bus     <= '0;
            enable_pulse <= 1'b0;
        end else begin
            sync_bus     <= pulse_comb ? unsync_bus : sync_bus;
            enable_pulse <= pulse_comb;
        end
    end

endmodule
